// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives a one-bit-per-clock serial line and delivers parallel
// words over a valid/ready handshake.
//
// The incoming line is first passed through a 2-flop synchroniser. A frame is
// one start bit (0), then DATA_W data bits sent LSB first, then one stop bit (1).
// The receiver takes one line sample per clock and does no oversampling.
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rest       synchronous active-low reset, sampled on the rising edge of clk
//   d          serial line, idle high, asynchronous to clk
//   out_ready  the consumer can accept out_data in this cycle
//   out_data   received word; bit 0 is the first data bit received
//   out_valid  out_data holds a word that has not been consumed yet
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a completed word is dropped because the
//              output register is still occupied
//   busy       high whenever the receiver is not idle
module serial_frame_rx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              d,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STOP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;

  // Synchroniser for the asynchronous line.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // Next-state logic for the framing FSM, the shift register and the output handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // The consumer takes the held word; a frame completing on the same edge can override this below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!s2_q) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end

      ST_DATA: begin
        // Shift right, entering at the MSB, so the first bit ends up in bit 0.
        shift_d = {s2_q, shift_q[DATA_W-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (s2_q) begin
          state_d = ST_IDLE;
          // Load when the output is free, or when the held word is being taken on this same edge.
          if (!out_valid_q || out_ready) begin
            out_data_d  = shift_q;
            out_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_BREAK;
        end
      end

      ST_BREAK: begin
        // Wait for the line to return high so that a held-low line cannot produce phantom frames.
        if (s2_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rest) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx with DATA_W = 8.
// Expected words go into a scoreboard queue when their frames are driven. They
// are popped and compared whenever the DUT hands a word over.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rest;
  logic       d;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic ferr_prev = 1'b0;
  logic ovr_prev = 1'b0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
  } vec_t;

  vec_t tbl[8];

  serial_frame_rx #(.DATA_W(8)) dut (
    .clk       (clk),
    .rest      (rest),
    .d         (d),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: count error pulses, check that each pulse lasts one cycle, and score every handshake.
  always @(negedge clk) begin
    if (rest) begin
      if (frame_err) begin
        ferr_cnt++;
        check("frame_err_one_cycle", 32'(ferr_prev), 32'd0);
      end
      if (overrun) begin
        ovr_cnt++;
        check("overrun_one_cycle", 32'(ovr_prev), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected_word: got 0x%0h, expected no word", out_data);
        end else begin
          check("sb_word", 32'(out_data), 32'(sb.pop_front()));
        end
      end
    end
    ferr_prev = frame_err;
    ovr_prev  = overrun;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    d = 1'b1;
    repeat (n) tick();
  endtask

  // Drive one frame. The task returns just after the edge that captures the stop bit, with the line left high.
  task automatic send_frame(input logic [7:0] data, input logic stop);
    d = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      d = data[i];
      tick();
    end
    d = stop;
    tick();
    d = 1'b1;
  endtask

  initial begin
    int ferr0;
    int ovr0;
    int exp_ferr;
    logic [7:0] abort_word;

    rest = 1'b0;
    d = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rest = 1'b1;
    idle(2);

    // Table of frames received with out_ready held high. A gap of 0 means the next frame follows back-to-back.
    tbl[0] = '{8'h00, 1'b1, 0};
    tbl[1] = '{8'hFF, 1'b1, 0};
    tbl[2] = '{8'h5A, 1'b1, 2};
    tbl[3] = '{8'h80, 1'b0, 3};
    tbl[4] = '{8'h01, 1'b1, 0};
    tbl[5] = '{8'hC3, 1'b0, 4};
    tbl[6] = '{8'h7F, 1'b1, 0};
    tbl[7] = '{8'h96, 1'b1, 3};
    out_ready = 1'b1;
    ferr0 = ferr_cnt;
    ovr0 = ovr_cnt;
    exp_ferr = 0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].stop) sb.push_back(tbl[i].data);
      else exp_ferr++;
      send_frame(tbl[i].data, tbl[i].stop);
      idle(tbl[i].gap);
    end
    idle(4);
    check("tbl_frame_err_count", 32'(ferr_cnt - ferr0), 32'(exp_ferr));
    check("tbl_overrun_count", 32'(ovr_cnt - ovr0), 32'd0);
    check("tbl_sb_drained", 32'(sb.size()), 32'd0);
    check("tbl_busy_idle", 32'(busy), 32'd0);

    // 0xA5: out_valid must rise exactly 11 edges after the start-bit edge and stay high for one cycle.
    ferr0 = ferr_cnt;
    ovr0 = ovr_cnt;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick();
    check("a5_valid_e10", 32'(out_valid), 32'd0);
    check("a5_busy_e10", 32'(busy), 32'd1);
    tick();
    check("a5_valid_e11", 32'(out_valid), 32'd1);
    check("a5_data_e11", 32'(out_data), 32'hA5);
    tick();
    check("a5_valid_e12", 32'(out_valid), 32'd0);
    check("a5_no_frame_err", 32'(ferr_cnt - ferr0), 32'd0);
    check("a5_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);

    // 0x3C then 0xC3 back-to-back with out_ready low: 0xC3 is dropped with one overrun pulse.
    out_ready = 1'b0;
    ovr0 = ovr_cnt;
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(4);
    check("ovr_valid_held", 32'(out_valid), 32'd1);
    check("ovr_data_held", 32'(out_data), 32'h3C);
    check("ovr_pulse_count", 32'(ovr_cnt - ovr0), 32'd1);
    out_ready = 1'b1;
    tick();
    check("ovr_consumed_valid", 32'(out_valid), 32'd0);
    check("ovr_sb_drained", 32'(sb.size()), 32'd0);

    // 0x55 with a bad stop bit, then the line held low: one frame_err pulse and a BREAK until the line returns high.
    ferr0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    d = 1'b0;
    repeat (20) tick();
    check("brk_busy_low_line", 32'(busy), 32'd1);
    check("brk_frame_err_count", 32'(ferr_cnt - ferr0), 32'd1);
    check("brk_no_valid", 32'(out_valid), 32'd0);
    d = 1'b1;
    tick();
    check("brk_busy_k0", 32'(busy), 32'd1);
    tick();
    check("brk_busy_k1", 32'(busy), 32'd1);
    tick();
    check("brk_busy_k2", 32'(busy), 32'd0);
    idle(2);
    sb.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    idle(4);
    check("brk_next_frame_err_count", 32'(ferr_cnt - ferr0), 32'd1);
    check("brk_next_sb_drained", 32'(sb.size()), 32'd0);

    // 0x7E completes on the same edge as the held 0x11 is taken: it loads with no overrun.
    out_ready = 1'b0;
    ovr0 = ovr_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    sb.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    tick();
    check("same_edge_old_valid", 32'(out_valid), 32'd1);
    check("same_edge_old_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    tick();
    check("same_edge_new_valid", 32'(out_valid), 32'd1);
    check("same_edge_new_data", 32'(out_data), 32'h7E);
    check("same_edge_overrun", 32'(overrun), 32'd0);
    tick();
    check("same_edge_drained_valid", 32'(out_valid), 32'd0);
    check("same_edge_overrun_count", 32'(ovr_cnt - ovr0), 32'd0);

    // Reset during data bit 4, while a word is held: the reset discards both the held word and the frame in flight.
    out_ready = 1'b0;
    sb.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    idle(3);
    check("rst_held_valid", 32'(out_valid), 32'd1);
    abort_word = 8'hC7;
    d = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      d = abort_word[i];
      tick();
    end
    d = abort_word[4];
    rest = 1'b0;
    tick();
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_data", 32'(out_data), 32'd0);
    check("rst_mid_frame_err", 32'(frame_err), 32'd0);
    check("rst_mid_overrun", 32'(overrun), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    sb.delete();
    d = 1'b1;
    rest = 1'b1;
    idle(3);
    ferr0 = ferr_cnt;
    ovr0 = ovr_cnt;
    out_ready = 1'b1;
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    tick();
    tick();
    check("rst_after_valid", 32'(out_valid), 32'd1);
    check("rst_after_data", 32'(out_data), 32'h81);
    idle(3);
    check("rst_after_frame_err", 32'(ferr_cnt - ferr0), 32'd0);
    check("rst_after_overrun", 32'(ovr_cnt - ovr0), 32'd0);
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Purpose: downstream consumer of the single-bit registered data stream (d/q flop chain). It synchronises the bit, frames it and delivers parallel bytes over a valid/ready handshake.

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rest  input  1  reset; synchronous, active-low; sampled on the rising edge of clk.
REQ-004 d  input  1  serial line; idle high; asynchronous to clk.
REQ-005 out_ready  input  1  consumer can accept out_data this cycle.
REQ-006 out_data  output  DATA_W  received word, bit 0 = first data bit received.
REQ-007 out_valid  output  1  out_data holds an unconsumed word.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: completed word dropped because the output was still occupied.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 d SHALL pass through a 2-flop synchroniser (s1 <= d, s2 <= s1); the FSM SHALL use only s2.
REQ-012 Frame format SHALL be 1 start bit (0), DATA_W data bits LSB first, then 1 stop bit (1), at one bit per clk cycle, with no oversampling.
REQ-013 The FSM SHALL have exactly these states: IDLE, DATA, STOP, BREAK.
REQ-014 IDLE: s2=0 -> DATA with bit counter cleared; s2=1 -> stay in IDLE.
REQ-015 DATA: each edge shifts s2 into the shift register at the MSB (shift right) and increments the counter; after DATA_W bits -> STOP.
REQ-016 STOP: s2=1 -> frame complete, go to IDLE; s2=0 -> pulse frame_err, discard the word, go to BREAK.
REQ-017 BREAK: stay while s2=0; s2=1 -> IDLE. A held-low line SHALL NOT produce repeated frames.
REQ-018 Latency: start bit captured by s1 at edge E0 -> FSM enters DATA at E0+2; out_valid rises after edge E0+DATA_W+3 (E0+11 for DATA_W=8).
REQ-019 Handshake: a transfer occurs on an edge with out_valid=1 and out_ready=1; out_valid clears after that edge unless a new word loads on the same edge.
REQ-020 While out_valid=1 and no transfer occurs, out_data SHALL hold stable.
REQ-021 Frame complete with out_valid=0 -> load out_data and set out_valid=1.
REQ-022 Frame complete with out_valid=1 and out_ready=1 on the same edge -> old word transfers, new word loads, out_valid stays 1, no overrun.
REQ-023 Frame complete with out_valid=1 and out_ready=0 -> new word dropped, old word kept, overrun pulses for 1 cycle.
REQ-024 A frame with a bad stop bit SHALL NOT alter out_data or out_valid.
REQ-025 Back-to-back frames (start bit immediately after stop bit) SHALL be received with no idle cycle required.
REQ-026 frame_err and overrun SHALL be high for exactly one cycle per event and low otherwise.

Reset
REQ-027 When rest=0 at an edge: s1=1, s2=1, state=IDLE, counter=0, shift register=0, out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0.
REQ-028 Reset mid-frame SHALL abort the frame with no out_valid, frame_err or overrun; after release, reception restarts from IDLE.
REQ-029 Reset asserted while out_valid=1 SHALL discard the held word.

Verification
REQ-030 Send 0xA5 with out_ready=1 -> out_valid high for 1 cycle exactly 11 cycles after the start-bit edge, out_data=0xA5, no error pulses.
REQ-031 Send 0x3C then 0xC3 back-to-back with out_ready=0 -> out_data stays 0x3C, overrun pulses once at the second stop bit; then out_ready=1 -> 0x3C consumed, out_valid=0.
REQ-032 Send 0x55 with stop bit 0, then line held low for 20 cycles, then high -> one frame_err pulse, no out_valid, busy high until 2 cycles after the line returns high; next frame 0x01 received correctly.
REQ-033 out_valid=1 and out_ready=1 on the same edge as a 0x7E frame completes -> old word transfers, out_data=0x7E, out_valid stays 1, overrun=0.
REQ-034 Assert rest=0 during data bit 4 of a frame -> all outputs 0 on the next edge; release; send 0x81 -> out_data=0x81 with no error pulses.
